// File: rtl/hazard_pkg.sv
// hazard_pkg: state type, widths and a saturating-increment helper shared by
// hazard_ctrl and hazard_match.
package hazard_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int STALL_CNT_W = 16;
    localparam int BUBBLE_MAX  = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2
    } state_t;

    // Count up by one, but stick at all-ones instead of wrapping to zero.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: reports whether a producer's destination register feeds a
// source operand of the instruction in ID. Register 0 never matches because
// it is hard-wired to zero.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_dest,
    input  logic [REG_IDX_W-1:0] i_rs,
    input  logic                 i_use_rs,
    input  logic [REG_IDX_W-1:0] i_rt,
    input  logic                 i_use_rt,
    output logic                 o_match
);

    assign o_match = (i_dest != '0) &&
                     ((i_use_rs && (i_dest == i_rs)) || (i_use_rt && (i_dest == i_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock for load-use and branch-operand hazards,
// memory-wait freeze, IF/ID flush on control transfers and a saturating
// stall-cycle counter.
// Build option: HAZARD_CTRL_DELAY_SLOT_EN defined -> never flush IF/ID, so
// the delay-slot instruction proceeds.
//
// state  | meaning
// RUN    | normal issue; hazards detected here (1-cycle stalls resolved in place)
// BUBBLE | extra bubble cycles still owed (count in r_rem), no re-detection
// FREEZE | data memory busy; everything holds, r_rem keeps the BUBBLE context
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_IDX_W-1:0]   rs_id,
    input  logic [REG_IDX_W-1:0]   rt_id,
    input  logic                   use_rs_id,
    input  logic                   use_rt_id,
    input  logic                   branch_id,
    input  logic                   branch_taken_id,
    input  logic                   jump_id,
    input  logic                   re_ex,
    input  logic                   we_ex,
    input  logic [REG_IDX_W-1:0]   dest_ex,
    input  logic                   re_mem,
    input  logic [REG_IDX_W-1:0]   dest_mem,
    input  logic                   mem_busy,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   freeze,
    output logic [STALL_CNT_W-1:0] stall_count
);

    state_t                 r_state;
    logic [1:0]             r_rem;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    state_t     w_eff_state;
    state_t     w_state_nxt;
    logic [1:0] w_rem_nxt;
    logic [1:0] w_need;
    logic       w_match_ex;
    logic       w_match_mem;
    logic       w_hold;
    logic       w_bubble;
    logic       w_freeze;
    logic       w_flush;

    hazard_match u_match_ex (
        .i_dest   (dest_ex),
        .i_rs     (rs_id),
        .i_use_rs (use_rs_id),
        .i_rt     (rt_id),
        .i_use_rt (use_rt_id),
        .o_match  (w_match_ex)
    );

    hazard_match u_match_mem (
        .i_dest   (dest_mem),
        .i_rs     (rs_id),
        .i_use_rs (use_rs_id),
        .i_rt     (rt_id),
        .i_use_rt (use_rt_id),
        .o_match  (w_match_mem)
    );

    // Bubble cycles demanded by the current hazards; the longest one wins.
    always_comb begin
        w_need = 2'd0;
        if ((re_ex && we_ex && w_match_ex) ||
            (branch_id && we_ex && !re_ex && w_match_ex) ||
            (branch_id && re_mem && w_match_mem))
            w_need = 2'd1;
        if (branch_id && re_ex && w_match_ex)
            w_need = 2'(BUBBLE_MAX);
    end

    // Leaving FREEZE resumes the preserved context in the same cycle, so the
    // owed bubble is issued right away rather than after an idle cycle.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == FREEZE)
            w_eff_state = (r_rem != 2'd0) ? BUBBLE : RUN;
    end

    // Next state and raw control outputs; memory wait overrides everything.
    always_comb begin
        w_state_nxt = w_eff_state;
        w_rem_nxt   = r_rem;
        w_hold      = 1'b0;
        w_bubble    = 1'b0;
        w_freeze    = 1'b0;
        if (mem_busy) begin
            w_freeze    = 1'b1;
            w_hold      = 1'b1;
            w_state_nxt = FREEZE;
        end else begin
            case (w_eff_state)
                RUN: begin
                    if (w_need != 2'd0) begin
                        w_hold   = 1'b1;
                        w_bubble = 1'b1;
                        if (w_need == 2'(BUBBLE_MAX)) begin
                            w_state_nxt = BUBBLE;
                            w_rem_nxt   = 2'(BUBBLE_MAX - 1);
                        end
                    end
                end
                BUBBLE: begin
                    w_hold    = 1'b1;
                    w_bubble  = 1'b1;
                    w_rem_nxt = r_rem - 2'd1;
                    if (r_rem <= 2'd1)
                        w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_DELAY_SLOT_EN
    logic w_xfer_unused;
    assign w_xfer_unused = branch_taken_id | jump_id;
    assign w_flush       = 1'b0;
`else
    // A held PC means the transfer has not been accepted yet, so no flush.
    assign w_flush = (branch_taken_id || jump_id) && !w_hold && !w_freeze;
`endif

    // Reset forces every control output low regardless of the other inputs.
    assign pc_hold     = w_hold   && !reset;
    assign ifid_hold   = w_hold   && !reset;
    assign idex_bubble = w_bubble && !reset;
    assign freeze      = w_freeze && !reset;
    assign ifid_flush  = w_flush  && !reset;
    assign stall_count = r_stall_cnt;

    // State, bubble context and stall counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_rem       <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_hold)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed tests for hazard_ctrl with hand-computed
// expectations. ctl = {pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze}.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_DELAY_SLOT_EN
    localparam bit FL = 1'b0;
`else
    localparam bit FL = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs_id, rt_id, dest_ex, dest_mem;
    logic        use_rs_id, use_rt_id, branch_id, branch_taken_id, jump_id;
    logic        re_ex, we_ex, re_mem, mem_busy;
    logic        pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze;
    logic [15:0] stall_count;
    logic [4:0]  ctl;

    int n_pass  = 0;
    int n_total = 0;

    assign ctl = {pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze};

    hazard_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .branch_id       (branch_id),
        .branch_taken_id (branch_taken_id),
        .jump_id         (jump_id),
        .re_ex           (re_ex),
        .we_ex           (we_ex),
        .dest_ex         (dest_ex),
        .re_mem          (re_mem),
        .dest_mem        (dest_mem),
        .mem_busy        (mem_busy),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .freeze          (freeze),
        .stall_count     (stall_count)
    );

    always #5 clock = ~clock;

    task automatic idle();
        rs_id = 0; rt_id = 0; dest_ex = 0; dest_mem = 0;
        use_rs_id = 0; use_rt_id = 0; branch_id = 0; branch_taken_id = 0;
        jump_id = 0; re_ex = 0; we_ex = 0; re_mem = 0; mem_busy = 0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic branch_on_load();
        idle();
        branch_id = 1; re_ex = 1; we_ex = 1; dest_ex = 9; rt_id = 9; use_rt_id = 1;
    endtask

    task automatic test_reset();
        idle();
        re_ex = 1; we_ex = 1; dest_ex = 8; rs_id = 8; use_rs_id = 1;
        branch_taken_id = 1; mem_busy = 1;
        reset = 1;
        tick();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_count); else n_pass++;
        tick();
        reset = 0;
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL idle_ctl: got %b expected %b", ctl, 5'b00000); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        re_ex = 1; we_ex = 1; dest_ex = 8; rs_id = 8; use_rs_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL load_use: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL load_use_after: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd1) $display("FAIL load_use_cnt: got %0d expected 1", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_branch_alu();
        idle();
        branch_id = 1; we_ex = 1; dest_ex = 3; rt_id = 3; use_rt_id = 0;
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL alu_unused_rt: got %b expected %b", ctl, 5'b00000); else n_pass++;
        tick();
        use_rt_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL branch_alu: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (stall_count !== 16'd2) $display("FAIL branch_alu_cnt: got %0d expected 2", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_branch_mem();
        idle();
        branch_id = 1; re_mem = 1; dest_mem = 12; rs_id = 12; use_rs_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL branch_mem: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL branch_mem_after: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd3) $display("FAIL branch_mem_cnt: got %0d expected 3", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_reg_zero();
        idle();
        re_ex = 1; we_ex = 1; dest_ex = 0; rs_id = 0; use_rs_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL reg_zero: got %b expected %b", ctl, 5'b00000); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (stall_count !== 16'd3) $display("FAIL reg_zero_cnt: got %0d expected 3", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_branch_load();
        branch_on_load();
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL bol_first: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL bol_second: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL bol_run: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd5) $display("FAIL bol_cnt: got %0d expected 5", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_freeze_in_bubble();
        branch_on_load();
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL fz_first_bubble: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_total++; if (ctl !== 5'b11001) $display("FAIL fz_cycle%0d: got %b expected %b", i, ctl, 5'b11001); else n_pass++;
            tick();
        end
        mem_busy = 0;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL fz_resume_bubble: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL fz_run: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd10) $display("FAIL fz_cnt: got %0d expected 10", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        idle();
        branch_taken_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== {4'b0000, 1'b0} + {3'b000, FL, 1'b0}) $display("FAIL flush_taken: got %b expected %b", ctl, {3'b000, FL, 1'b0}); else n_pass++;
        tick();
        idle();
        jump_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== {3'b000, FL, 1'b0}) $display("FAIL flush_jump: got %b expected %b", ctl, {3'b000, FL, 1'b0}); else n_pass++;
        tick();
        idle();
        branch_taken_id = 1; re_ex = 1; we_ex = 1; dest_ex = 8; rs_id = 8; use_rs_id = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11100) $display("FAIL flush_vs_stall: got %b expected %b", ctl, 5'b11100); else n_pass++;
        tick();
        idle();
        jump_id = 1; mem_busy = 1;
        @(negedge clock);
        n_total++; if (ctl !== 5'b11001) $display("FAIL flush_vs_freeze: got %b expected %b", ctl, 5'b11001); else n_pass++;
        tick();
        idle();
        @(negedge clock);
        n_total++; if (stall_count !== 16'd12) $display("FAIL flush_cnt: got %0d expected 12", stall_count); else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        idle();
        reset = 1;
        tick();
        reset = 0;
        mem_busy = 1;
        repeat (16'hFFFE) tick();
        n_total++; if (stall_count !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", stall_count); else n_pass++;
        repeat (3) tick();
        n_total++; if (stall_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", stall_count); else n_pass++;
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL sat_idle: got %b expected %b", ctl, 5'b00000); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        branch_on_load();
        tick();
        idle();
        #1;
        n_total++; if (ctl !== 5'b11100) $display("FAIL mid_bubble: got %b expected %b", ctl, 5'b11100); else n_pass++;
        reset = 1;
        #1;
        n_total++; if (ctl !== 5'b00000) $display("FAIL rst_bubble_ctl: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd0) $display("FAIL rst_async_cnt: got %0d expected 0", stall_count); else n_pass++;
        tick();
        reset = 0;
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL rst_bubble_run: got %b expected %b", ctl, 5'b00000); else n_pass++;
        tick();
        branch_on_load();
        tick();
        idle();
        mem_busy = 1;
        tick();
        reset = 1;
        tick();
        reset = 0;
        idle();
        @(negedge clock);
        n_total++; if (ctl !== 5'b00000) $display("FAIL rst_freeze_run: got %b expected %b", ctl, 5'b00000); else n_pass++;
        n_total++; if (stall_count !== 16'd0) $display("FAIL rst_freeze_cnt: got %0d expected 0", stall_count); else n_pass++;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_mem();
        test_reg_zero();
        test_branch_load();
        test_freeze_in_bubble();
        test_flush();
        test_saturation();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
